// File: rtl/cache_pkg.sv
// Shared types and constants for the cache memory-side bridge.
// Provides bridge FSM state codes, AXI response codes and line geometry helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic int words_per_line(input int line_bytes,
                                          input int data_width);
        return line_bytes / (data_width / 8);
    endfunction

    function automatic int offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/line_axil_bridge.sv
// Whole-line cache backend to AXI4-Lite manager: one single-beat AXI
// transaction per line word, one line request in flight at a time.
// Ports: clk, rst_n (async low); mem_req_* / mem_resp_* line side;
// m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite manager side.
// Option: LINE_BRIDGE_ERR_EN adds mem_resp_err (sticky bresp/rresp error).
module line_axil_bridge
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int LINE_BITS  = LINE_BYTES * 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req_valid,
    output logic                    mem_req_ready,
    input  logic                    mem_req_we,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [LINE_BITS-1:0]    mem_req_wline,
    output logic                    mem_resp_valid,
    output logic [LINE_BITS-1:0]    mem_resp_rline,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
`ifdef LINE_BRIDGE_ERR_EN
    ,
    output logic                    mem_resp_err
`endif
);

    localparam int WPL = words_per_line(LINE_BYTES, DATA_WIDTH);
    localparam int OFF = offset_bits(LINE_BYTES);
    localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int BSH = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

    bridge_state_e state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [LINE_BITS-1:0]  rline_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  last;
    logic                  accept;

    assign word_addr = addr_q + (ADDR_WIDTH'(cnt_q) << BSH);
    assign last      = (cnt_q == CW'(WPL - 1));
    assign accept    = (state_q == S_IDLE) && mem_req_valid;

    assign m_awaddr       = word_addr;
    assign m_araddr       = word_addr;
    assign m_awprot       = 3'b000;
    assign m_arprot       = 3'b000;
    assign m_wstrb        = '1;
    assign m_wdata        = line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign mem_resp_rline = rline_q;

    always_comb begin
        state_d        = state_q;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        m_awvalid      = 1'b0;
        m_wvalid       = 1'b0;
        m_bready       = 1'b0;
        m_arvalid      = 1'b0;
        m_rready       = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_req_ready = 1'b1;
                if (mem_req_valid)
                    state_d = mem_req_we ? S_WR_ADDR : S_RD_ADDR;
            end
            S_WR_ADDR: begin
                // AW and W retire independently; leave once both are in.
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if ((aw_done_q || m_awready) && (w_done_q || m_wready))
                    state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid)
                    state_d = last ? S_RESP : S_WR_ADDR;
            end
            S_RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready)
                    state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid)
                    state_d = last ? S_RESP : S_RD_ADDR;
            end
            S_RESP: begin
                mem_resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            rline_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= mem_req_addr & ALIGN_MASK;
                line_q <= mem_req_wline;
                cnt_q  <= '0;
            end
            if (state_q == S_WR_ADDR) begin
                if (state_d == S_WR_RESP) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end else begin
                    if (m_awvalid && m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
                end
            end
            if (((state_q == S_WR_RESP) && m_bvalid && !last) ||
                ((state_q == S_RD_DATA) && m_rvalid && !last))
                cnt_q <= cnt_q + CW'(1);
            if ((state_q == S_RD_DATA) && m_rvalid)
                rline_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= m_rdata;
        end
    end

`ifdef LINE_BRIDGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else begin
            if (m_bvalid && m_bready && (m_bresp != OKAY)) err_q <= 1'b1;
            if (m_rvalid && m_rready && (m_rresp != OKAY)) err_q <= 1'b1;
        end
    end

    assign mem_resp_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp};
`endif

endmodule

// File: tb/tb_line_axil_bridge.sv
// Directed bench for line_axil_bridge with a negedge-driven AXI4-Lite slave.
// Prints one summary line: test done: total=<n> bad=<n>
module tb_line_axil_bridge;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_req_valid = 1'b0;
    logic         mem_req_ready;
    logic         mem_req_we = 1'b0;
    logic [31:0]  mem_req_addr = '0;
    logic [127:0] mem_req_wline = '0;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rline;
    logic         m_awvalid, m_awready = 1'b0;
    logic [31:0]  m_awaddr;
    logic [2:0]   m_awprot, m_arprot;
    logic         m_wvalid, m_wready = 1'b0;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_bvalid = 1'b0, m_bready;
    logic [1:0]   m_bresp = 2'b00;
    logic         m_arvalid, m_arready = 1'b0;
    logic [31:0]  m_araddr;
    logic         m_rvalid = 1'b0, m_rready;
    logic [31:0]  m_rdata = '0;
    logic [1:0]   m_rresp = 2'b00;
`ifdef LINE_BRIDGE_ERR_EN
    logic         mem_resp_err;
`endif

    line_axil_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wline(mem_req_wline),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rline(mem_resp_rline),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp)
`ifdef LINE_BRIDGE_ERR_EN
        , .mem_resp_err(mem_resp_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit rand_mode = 1'b0;
    logic [31:0] rd_words [4];
    logic [1:0]  rresp_tab [4];
    logic [31:0] ar_last = '0;

    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    int aw_hi = 0, w_hi = 0, resp_cnt = 0, side_err = 0, ready_viol = 0;
    logic [127:0] rline_seen = '0;
    logic err_seen = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [31:0] q[$],
                         input logic [31:0] base, input logic [31:0] step);
        chk({tag, "_n"}, 128'(q.size()), 128'd4);
        for (int i = 0; i < q.size(); i++)
            chk($sformatf("%s%0d", tag, i), 128'(q[i]),
                128'(base + step * 32'(i)));
    endtask

    // Slave: readies/valids change only on negedges; handshakes are
    // logged here because nothing moves again before the next posedge.
    always @(negedge clk) begin
        if (!m_awvalid) begin m_awready = 1'b0; aw_cnt = 0; end
        else if (aw_cnt >= aw_delay) m_awready = 1'b1;
        else aw_cnt++;
        if (!m_wvalid) begin m_wready = 1'b0; w_cnt = 0; end
        else if (w_cnt >= w_delay) m_wready = 1'b1;
        else w_cnt++;
        if (!m_arvalid) begin m_arready = 1'b0; ar_cnt = 0; end
        else if (ar_cnt >= ar_delay) m_arready = 1'b1;
        else ar_cnt++;
        if (!m_bready) begin
            m_bvalid = 1'b0; b_cnt = 0;
            if (rand_mode) b_delay = $urandom_range(0, 5);
        end else if (b_cnt >= b_delay) m_bvalid = 1'b1;
        else b_cnt++;
        if (!m_rready) begin
            m_rvalid = 1'b0; r_cnt = 0;
            if (rand_mode) r_delay = $urandom_range(0, 5);
        end else if (r_cnt >= r_delay) begin
            m_rvalid = 1'b1;
            m_rdata  = rd_words[ar_last[3:2]];
            m_rresp  = rresp_tab[ar_last[3:2]];
        end else r_cnt++;
        if (m_awvalid) aw_hi++;
        if (m_wvalid)  w_hi++;
        if (m_awvalid && m_awready) begin
            aw_log.push_back(m_awaddr);
            if (m_awprot != 3'd0) side_err++;
        end
        if (m_wvalid && m_wready) begin
            w_log.push_back(m_wdata);
            if (m_wstrb != 4'hF) side_err++;
        end
        if (m_arvalid && m_arready) begin
            ar_log.push_back(m_araddr);
            ar_last = m_araddr;
            if (m_arprot != 3'd0) side_err++;
        end
        if (mem_resp_valid) begin
            resp_cnt++;
            rline_seen = mem_resp_rline;
`ifdef LINE_BRIDGE_ERR_EN
            err_seen = mem_resp_err;
`endif
        end
    end

    task automatic start_req(input logic we, input logic [31:0] addr,
                             input logic [127:0] wl);
        @(negedge clk); #1;
        mem_req_valid = 1'b1;
        mem_req_we    = we;
        mem_req_addr  = addr;
        mem_req_wline = wl;
        @(negedge clk); #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic line_req(input logic we, input logic [31:0] addr,
                            input logic [127:0] wl, output int lat);
        int base;
        base = resp_cnt;
        lat  = -1;
        aw_log.delete(); w_log.delete(); ar_log.delete();
        aw_hi = 0; w_hi = 0;
        start_req(we, addr, wl);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk); #1;
            if (mem_req_ready) ready_viol++;
            if (resp_cnt != base) begin lat = k; break; end
        end
        chk("resp_seen", 128'(lat > 0), 128'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("one_pulse", 128'(resp_cnt - base), 128'd1);
    endtask

    int lat;
    int base;

    initial begin
        rd_words  = '{32'h11, 32'h22, 32'h33, 32'h44};
        rresp_tab = '{2'b00, 2'b00, 2'b00, 2'b00};
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 128'(mem_req_ready), 128'd1);
        chk("rst_valids", 128'({m_awvalid, m_wvalid, m_arvalid,
                                m_bready, m_rready}), 128'd0);
        chk("rst_resp", 128'(mem_resp_valid), 128'd0);
        chk("rst_rline", mem_resp_rline, 128'd0);
        rst_n = 1'b1;

        line_req(1'b0, 32'h0000_1234, '0, lat);
        chk("rd_lat", 128'(lat), 128'd8);
        chk_q("rd_araddr", ar_log, 32'h1230, 32'd4);
        chk("rd_rline", rline_seen,
            128'h00000044_00000033_00000022_00000011);

        line_req(1'b1, 32'h0000_2000,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, lat);
        chk("wr_lat", 128'(lat), 128'd8);
        chk_q("wr_awaddr", aw_log, 32'h2000, 32'd4);
        chk_q("wr_wdata", w_log, 32'hA0, 32'd1);
        chk("wr_keeps_rline", mem_resp_rline,
            128'h00000044_00000033_00000022_00000011);

        aw_delay = 3;
        line_req(1'b1, 32'h0000_3008,
                 {32'hB3, 32'hB2, 32'hB1, 32'hB0}, lat);
        aw_delay = 0;
        chk("awdly_aw_hi", 128'(aw_hi), 128'd16);
        chk("awdly_w_hi", 128'(w_hi), 128'd4);
        chk_q("awdly_awaddr", aw_log, 32'h3000, 32'd4);
        chk_q("awdly_wdata", w_log, 32'hB0, 32'd1);

        rand_mode = 1'b1;
        rd_words  = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        line_req(1'b0, 32'h0000_6010, '0, lat);
        chk_q("rnd_araddr", ar_log, 32'h6010, 32'd4);
        chk("rnd_rline", rline_seen,
            128'h000000C3_000000C2_000000C1_000000C0);
        line_req(1'b1, 32'h0000_7000,
                 {32'hD3, 32'hD2, 32'hD1, 32'hD0}, lat);
        chk_q("rnd_wdata", w_log, 32'hD0, 32'd1);
        rand_mode = 1'b0;
        b_delay = 0;
        r_delay = 0;

        r_delay = 3;
        base = resp_cnt;
        ar_log.delete();
        start_req(1'b0, 32'h0000_8000, '0);
        for (int k = 0; k < 100 && ar_log.size() < 3; k++)
            @(negedge clk);
        chk("rst_reach_beat3", 128'(ar_log.size()), 128'd3);
        @(negedge clk); #1;
        chk("rst_in_rdata", 128'(m_rready), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valids", 128'({m_awvalid, m_wvalid, m_arvalid,
                                 m_bready, m_rready}), 128'd0);
        chk("arst_resp", 128'(mem_resp_valid), 128'd0);
        chk("arst_rline", mem_resp_rline, 128'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("arst_no_pulse", 128'(resp_cnt - base), 128'd0);
        r_delay = 0;
        rd_words = '{32'h55, 32'h66, 32'h77, 32'h88};
        line_req(1'b0, 32'h0000_0040, '0, lat);
        chk_q("post_araddr", ar_log, 32'h40, 32'd4);
        chk("post_rline", rline_seen,
            128'h00000088_00000077_00000066_00000055);

`ifdef LINE_BRIDGE_ERR_EN
        rresp_tab[2] = SLVERR;
        line_req(1'b0, 32'h0000_0100, '0, lat);
        chk("err_set", 128'(err_seen), 128'd1);
        rresp_tab[2] = OKAY;
        line_req(1'b0, 32'h0000_0200, '0, lat);
        chk("err_clear", 128'(err_seen), 128'd0);
`endif

        chk("req_ready_low", 128'(ready_viol), 128'd0);
        chk("prot_strb", 128'(side_err), 128'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
